// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: prefetching instruction fetch with redirect flush and halt-word drain
module instr_fetch_unit #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        instr_ovr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, fl_pc_q, fl_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d, hold_pc_q, hold_pc_d;
  logic fl_q, fl_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] mem_inst_q [DEPTH];
  logic [31:0] mem_inst_d [DEPTH];
  logic [31:0] mem_pc_q [DEPTH];
  logic [31:0] mem_pc_d [DEPTH];
  logic active, redir, capture, pop;
  always_comb begin
    active = state_q == IDLE || state_q == FETCH;
    redir = redirect && state_q != HALT;
    capture = fl_q && active && !redir;
    inst_valid = count_q != '0 && state_q != HALT;
    pop = inst_valid && inst_ready;
    inst = inst_valid ? mem_inst_q[head_q] : hold_inst_q;
    inst_pc = inst_valid ? mem_pc_q[head_q] : hold_pc_q;
    imem_req = !reset && active && pc_en && !redir && (count_q + CW'(fl_q) < FULL);
    imem_addr = fetch_pc_q;
    instr_ovr = state_q == HALT;
    hold_inst_d = inst;
    hold_pc_d = inst_pc;
    fl_d = imem_req;
    fl_pc_d = fetch_pc_q;
    mem_inst_d = mem_inst_q;
    mem_pc_d = mem_pc_q;
    if (capture) begin
      mem_inst_d[tail_q] = imem_rdata;
      mem_pc_d[tail_q] = fl_pc_q;
    end
    head_d = redir ? '0 : head_q + AW'(pop);
    tail_d = redir ? '0 : tail_q + AW'(capture);
    count_d = redir ? '0 : count_q + CW'(capture) - CW'(pop);
    fetch_pc_d = redir ? {redirect_pc[31:2], 2'b00} : imem_req ? fetch_pc_q + 32'd4 : fetch_pc_q;
    state_d = state_q;
    if (redir)
      state_d = pc_en ? FETCH : IDLE;
    else if (active)
      state_d = (capture && imem_rdata == HALT_WORD) ? DRAIN : pc_en ? FETCH : IDLE;
    else if (state_q == DRAIN && pop && count_q == CW'(1))
      state_d = HALT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      fl_q <= 1'b0;
      fl_pc_q <= '0;
      hold_inst_q <= '0;
      hold_pc_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      mem_inst_q <= '{default: '0};
      mem_pc_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fl_q <= fl_d;
      fl_pc_q <= fl_pc_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q <= hold_pc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      mem_inst_q <= mem_inst_d;
      mem_pc_q <= mem_pc_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random checks of the fetch unit against a queue-based model
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic reset, pc_en, redirect, inst_ready, imem_req, inst_valid, instr_ovr;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, inst, inst_pc;
  bit halt_en = 1'b0;
  logic [31:0] halt_addr = '0;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic [31:0] i; logic [31:0] pc;} ent_t;
  ent_t q[$];
  logic m_fl;
  logic [31:0] m_flpc, m_pc, m_li, m_lpc;
  bit m_drain, m_halt;
  logic e_req, e_valid, e_ovr;
  logic [31:0] e_addr, e_inst, e_pc;
  logic [98:0] obs, exp;
  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .inst(inst),
    .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready), .instr_ovr(instr_ovr)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (halt_en && a == halt_addr) ? HALT : {2'b00, a[31:2]};
  endfunction
  always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;
  task automatic set_in(input logic rst, pe, rdy, rd, input logic [31:0] rpc);
    reset = rst;
    pc_en = pe;
    inst_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
  endtask
  task automatic predict();
    e_valid = q.size() > 0 && !m_halt;
    e_inst = e_valid ? q[0].i : m_li;
    e_pc = e_valid ? q[0].pc : m_lpc;
    e_req = !reset && !m_halt && !m_drain && pc_en && !redirect && (q.size() + int'(m_fl) < DEPTH);
    e_addr = m_pc;
    e_ovr = m_halt;
  endtask
  task automatic snap();
    #1;
    predict();
    obs = {imem_req, inst_valid, instr_ovr, imem_addr, inst, inst_pc};
    exp = {e_req, e_valid, e_ovr, e_addr, e_inst, e_pc};
  endtask
  task automatic advance();
    bit popped, got, was_drain;
    logic [31:0] w;
    if (reset) begin
      q.delete();
      m_fl = 1'b0;
      m_pc = RESET_PC;
      m_li = '0;
      m_lpc = '0;
      m_drain = 1'b0;
      m_halt = 1'b0;
    end else begin
      m_li = e_inst;
      m_lpc = e_pc;
      if (redirect && !m_halt) begin
        q.delete();
        m_fl = 1'b0;
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        m_drain = 1'b0;
      end else begin
        was_drain = m_drain;
        popped = e_valid && inst_ready;
        got = m_fl && !m_drain && !m_halt;
        if (popped) void'(q.pop_front());
        if (got) begin
          w = mem_word(m_flpc);
          q.push_back(ent_t'({w, m_flpc}));
          if (w == HALT) m_drain = 1'b1;
        end
        if (was_drain && popped && q.size() == 0) begin
          m_halt = 1'b1;
          m_drain = 1'b0;
        end
        m_fl = e_req;
        m_flpc = m_pc;
        if (e_req) m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    set_in(1, 0, 0, 0, '0);
    advance();
  endtask
  task automatic test_reset();
    set_in(1, 1, 1, 1, 32'h0000_0040);
    advance();
    advance();
    snap();
    n_cmp++;
    if (obs !== {3'b000, RESET_PC, 64'h0}) begin
      n_bad++;
      $display("FAIL reset_state: got %h want %h", obs, {3'b000, RESET_PC, 64'h0});
    end
    advance();
    snap();
    n_cmp++;
    if (obs !== {3'b000, RESET_PC, 64'h0}) begin
      n_bad++;
      $display("FAIL reset_over_redirect: got %h want %h", obs, {3'b000, RESET_PC, 64'h0});
    end
  endtask
  task automatic test_stream();
    logic [98:0] want;
    halt_en = 1'b0;
    do_reset();
    set_in(0, 1, 1, 0, '0);
    for (int c = 0; c < 20; c++) begin
      snap();
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL stream_model c%0d: got %h want %h", c, obs, exp);
      end
      want = {1'b1, c >= 2, 1'b0, 32'(4 * c), c >= 2 ? 32'(c - 2) : 32'h0, c >= 2 ? 32'(4 * (c - 2)) : 32'h0};
      n_cmp++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL stream_order c%0d: got %h want %h", c, obs, want);
      end
      advance();
    end
  endtask
  task automatic test_backpressure();
    int reqs;
    logic [31:0] nxt;
    halt_en = 1'b0;
    do_reset();
    set_in(0, 1, 0, 0, '0);
    reqs = 0;
    for (int c = 0; c < 10; c++) begin
      snap();
      reqs += int'(imem_req);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL stall_model c%0d: got %h want %h", c, obs, exp);
      end
      if (c >= 2) begin
        n_cmp++;
        if (!(inst_valid === 1'b1 && inst_pc === 32'h0 && inst === 32'h0)) begin
          n_bad++;
          $display("FAIL stall_head c%0d: got v=%b pc=%h i=%h want v=1 pc=0 i=0", c, inst_valid, inst_pc, inst);
        end
      end
      advance();
    end
    n_cmp++;
    if (reqs != DEPTH) begin
      n_bad++;
      $display("FAIL stall_reqs: got %0d want %0d", reqs, DEPTH);
    end
    set_in(0, 1, 1, 0, '0);
    nxt = '0;
    for (int c = 0; c < 15; c++) begin
      snap();
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL release_model c%0d: got %h want %h", c, obs, exp);
      end
      if (inst_valid) begin
        n_cmp++;
        if (inst_pc !== nxt || inst !== {2'b00, nxt[31:2]}) begin
          n_bad++;
          $display("FAIL release_order c%0d: got pc=%h i=%h want pc=%h", c, inst_pc, inst, nxt);
        end
        nxt = nxt + 32'd4;
      end
      advance();
    end
    n_cmp++;
    if (nxt < 32'd16) begin
      n_bad++;
      $display("FAIL release_count: got %0d want >=16", nxt);
    end
  endtask
  task automatic test_redirect();
    logic [31:0] nxt;
    halt_en = 1'b0;
    do_reset();
    set_in(0, 1, 0, 0, '0);
    for (int c = 0; c < 4; c++) begin
      snap();
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL redir_fill c%0d: got %h want %h", c, obs, exp);
      end
      advance();
    end
    set_in(0, 1, 0, 1, 32'h0000_0102);
    snap();
    n_cmp++;
    if (obs !== exp || imem_req !== 1'b0 || inst_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL redir_cycle: got %h want %h", obs, exp);
    end
    advance();
    set_in(0, 1, 1, 0, '0);
    snap();
    n_cmp++;
    if (!(imem_req === 1'b1 && imem_addr === 32'h0000_0100 && inst_valid === 1'b0)) begin
      n_bad++;
      $display("FAIL redir_target: got req=%b addr=%h v=%b want req=1 addr=00000100 v=0", imem_req, imem_addr, inst_valid);
    end
    nxt = 32'h0000_0100;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) snap();
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL redir_model c%0d: got %h want %h", c, obs, exp);
      end
      if (inst_valid) begin
        n_cmp++;
        if (inst_pc !== nxt) begin
          n_bad++;
          $display("FAIL redir_order c%0d: got pc=%h want %h", c, inst_pc, nxt);
        end
        nxt = nxt + 32'd4;
      end
      advance();
    end
  endtask
  task automatic test_halt();
    logic [31:0] nxt, last_req;
    halt_en = 1'b1;
    halt_addr = 32'h0000_0014;
    do_reset();
    set_in(0, 1, 1, 0, '0);
    nxt = '0;
    last_req = '0;
    for (int c = 0; c < 25; c++) begin
      snap();
      if (imem_req) last_req = imem_addr;
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL halt_model c%0d: got %h want %h", c, obs, exp);
      end
      if (inst_valid) begin
        n_cmp++;
        if (inst_pc !== nxt || inst !== (nxt == 32'h14 ? HALT : {2'b00, nxt[31:2]})) begin
          n_bad++;
          $display("FAIL halt_order c%0d: got pc=%h i=%h want pc=%h", c, inst_pc, inst, nxt);
        end
        nxt = nxt + 32'd4;
      end
      advance();
    end
    n_cmp++;
    if (last_req !== 32'h18 || nxt !== 32'h18) begin
      n_bad++;
      $display("FAIL halt_span: got last_req=%h delivered_to=%h want 00000018 00000018", last_req, nxt);
    end
    for (int c = 0; c < 5; c++) begin
      set_in(0, 1, 1, 1, $urandom_range(0, 255));
      snap();
      n_cmp++;
      if (obs !== exp || imem_req !== 1'b0 || inst_valid !== 1'b0 || instr_ovr !== 1'b1) begin
        n_bad++;
        $display("FAIL halt_sticky c%0d: got %h want %h", c, obs, exp);
      end
      advance();
    end
  endtask
  task automatic test_reset_mid();
    logic [31:0] nxt;
    halt_en = 1'b0;
    do_reset();
    set_in(0, 1, 0, 0, '0);
    for (int c = 0; c < 8; c++) begin
      snap();
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL rstmid_fill c%0d: got %h want %h", c, obs, exp);
      end
      advance();
    end
    set_in(1, 1, 0, 1, 32'h0000_0040);
    snap();
    advance();
    set_in(0, 1, 1, 0, '0);
    snap();
    n_cmp++;
    if (!(inst_valid === 1'b0 && imem_addr === RESET_PC && imem_req === 1'b1 && instr_ovr === 1'b0)) begin
      n_bad++;
      $display("FAIL rstmid_state: got v=%b addr=%h req=%b want v=0 addr=%h req=1", inst_valid, imem_addr, imem_req, RESET_PC);
    end
    nxt = RESET_PC;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) snap();
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL rstmid_model c%0d: got %h want %h", c, obs, exp);
      end
      if (inst_valid) begin
        n_cmp++;
        if (inst_pc !== nxt) begin
          n_bad++;
          $display("FAIL rstmid_order c%0d: got pc=%h want %h", c, inst_pc, nxt);
        end
        nxt = nxt + 32'd4;
      end
      advance();
    end
  endtask
  task automatic test_wrap();
    logic [31:0] want;
    halt_en = 1'b0;
    do_reset();
    set_in(0, 1, 1, 1, 32'hFFFF_FFFB);
    snap();
    advance();
    set_in(0, 1, 1, 0, '0);
    for (int c = 0; c < 6; c++) begin
      snap();
      want = 32'hFFFF_FFF8 + 32'(4 * c);
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL wrap_model c%0d: got %h want %h", c, obs, exp);
      end
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== want) begin
        n_bad++;
        $display("FAIL wrap_addr c%0d: got req=%b addr=%h want req=1 addr=%h", c, imem_req, imem_addr, want);
      end
      advance();
    end
  endtask
  task automatic test_random();
    logic rst;
    halt_en = 1'b1;
    halt_addr = 32'h0000_0060;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = $urandom_range(0, 49) == 0;
      if (rst) halt_addr = 32'($urandom_range(8, 40)) << 2;
      set_in(rst, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, $urandom_range(0, 11) == 0, $urandom_range(0, 200));
      snap();
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL random c%0d: got %h want %h", c, obs, exp);
      end
      advance();
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
